led_channel_ctrl: RTL and testbench
===================================

LED_CHANNEL_CTRL -- requirements
Module: led_channel_ctrl

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 8, number of LED channels (legal 1..26).
REQ-002 The block SHALL have parameter PWM_BITS, default 3, PWM resolution in bits (legal 1..4).
REQ-003 The block SHALL have parameter BLINK_DIV, default 5_167_000, clk cycles per blink half-period (legal >=2).
REQ-004 The block SHALL have parameter TIMEOUT, default 1_033_400, max idle clk cycles between bytes of a multi-byte command (legal >=2).
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port rx_valid, input, 1, a one-cycle strobe marking rx_data as a new command byte.
REQ-008 The block SHALL have port rx_data, input, 8, the ASCII command byte.
REQ-009 The block SHALL have port overlay, input, CHANNELS, an external pattern ORed with the forced-on state.
REQ-010 The block SHALL have port led, output, CHANNELS, registered LED drive, active-high.
REQ-011 The block SHALL have port force_state, output, CHANNELS, the current forced-on register.
REQ-012 The block SHALL have port cmd_err, output, 1, a one-cycle pulse on a rejected byte or timeout.
REQ-013 The block SHALL have port busy, output, 1, high while the parser is not in IDLE.

Function
REQ-014 Single-byte commands in IDLE SHALL act as follows:
- 'A'+i sets force[i].
- 'a'+i clears force[i].
- '@' sets all force bits.
- '`' clears all force bits.
REQ-015 '#' in IDLE SHALL enter DUTY_CH; a channel letter ('A'+i or 'a'+i) SHALL then enter DUTY_VAL with i latched; a hex digit (0-9, A-F, a-f) SHALL then set duty[i] = nibble >> (4-PWM_BITS) and return to IDLE.
REQ-016 '!' in IDLE SHALL enter BLINK_CH; a channel letter SHALL then toggle blink_en[i] and return to IDLE.
REQ-017 A letter with i >= CHANNELS, a non-hex byte in DUTY_VAL, a non-letter in DUTY_CH/BLINK_CH, or any other byte in IDLE SHALL pulse cmd_err, change no channel state, and return the parser to IDLE.
REQ-018 All state updates SHALL occur on the edge sampling rx_valid=1; bytes with rx_valid=0 SHALL be ignored.
REQ-019 The PWM counter SHALL count 0..2^PWM_BITS-2 and wrap to 0 (period 2^PWM_BITS-1 cycles); pwm_on[i] = (counter < duty[i]), so duty 0 is always off and all-ones is always on.
REQ-020 The blink divider SHALL toggle blink_phase every BLINK_DIV cycles.
REQ-021 led[i] SHALL be registered as (force[i] | overlay[i]) & pwm_on[i] & (~blink_en[i] | blink_phase).
REQ-022 A command byte SHALL therefore be visible on led two edges after it is sampled.
REQ-023 The timeout counter SHALL clear on every accepted byte and count while busy; at TIMEOUT cycles the parser SHALL return to IDLE with one cmd_err pulse.
REQ-024 If a byte arrives on the same cycle the timeout expires, the byte SHALL be processed in the current state and no timeout pulse SHALL be issued.
REQ-025 force_state SHALL equal the force register with zero latency.
REQ-026 busy SHALL be high in DUTY_CH, DUTY_VAL and BLINK_CH.

Reset
REQ-027 While reset_n=0, outputs and state SHALL be held asynchronously as follows:
- led, force_state, cmd_err and busy = 0.
- All duty = 2^PWM_BITS-1.
- blink_en = 0.
- blink_phase = 1.
- PWM, blink and timeout counters = 0.
- Parser = IDLE.
REQ-028 Reset asserted mid-command SHALL discard the partial command.
REQ-029 The first byte after reset_n deasserts SHALL be parsed from IDLE.

Verification
REQ-030 Defaults, byte 'C' -> force_state=0x04, led[2]=1 two edges later, steady.
REQ-031 '@' then bytes '#','B','0' -> led[1] constantly 0; others 1; busy high for exactly two sampled bytes.
REQ-032 PWM_BITS=3, bytes '#','A','8' (duty=4) -> led[0] high 4 of every 7 cycles.
REQ-033 'A', '!','A', BLINK_DIV=4 -> led[0] alternates 4 cycles on / 4 off; a second '!','A' gives steady on.
REQ-034 CHANNELS=8, byte 'J' -> one cmd_err pulse, force_state unchanged.
REQ-035 Byte '#' and nothing else -> after TIMEOUT cycles, one cmd_err pulse and busy=0.
REQ-036 Byte '#' then reset_n low -> busy=0 immediately.
REQ-037 Byte '#', reset released, then bytes 'B','0' -> 'B' sets force[1] and '0' pulses cmd_err.

Source files
------------

// File: rtl/led_channel_ctrl.sv
// LED channel controller: ASCII byte command parser driving per-channel
// force-on, PWM duty and blink enables, with a registered LED output stage.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for a command byte; single-byte commands act here
// S_DUTY_CH  | '#' seen, waiting for the channel letter
// S_DUTY_VAL | channel latched, waiting for the hex duty digit
// S_BLINK_CH | '!' seen, waiting for the channel letter to toggle blink
module led_channel_ctrl #(
    parameter int CHANNELS  = 8,
    parameter int PWM_BITS  = 3,
    parameter int BLINK_DIV = 5_167_000,
    parameter int TIMEOUT   = 1_033_400
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    input  logic [CHANNELS-1:0] overlay,
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] force_state,
    output logic                cmd_err,
    output logic                busy
);

    localparam int BLK_W = $clog2(BLINK_DIV);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam logic [BLK_W-1:0]    BLK_LAST = BLK_W'(BLINK_DIV - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DUTY_CH,
        S_DUTY_VAL,
        S_BLINK_CH
    } state_t;

    state_t                              state_q, state_d;
    logic [CHANNELS-1:0]                 force_q, force_d;
    logic [CHANNELS-1:0]                 blink_en_q, blink_en_d;
    logic [CHANNELS-1:0][PWM_BITS-1:0]   duty_q, duty_d;
    logic [CHANNELS-1:0]                 ch_mask_q, ch_mask_d;
    logic [TMO_W-1:0]                    tmo_cnt_q, tmo_cnt_d;
    logic                                err_q, err_d;
    logic [PWM_BITS-1:0]                 pwm_cnt_q;
    logic [BLK_W-1:0]                    blink_cnt_q;
    logic                                blink_phase_q;
    logic [CHANNELS-1:0]                 led_q;

    logic                is_upper, is_lower, letter_ok;
    logic [4:0]          letter_idx;
    logic [CHANNELS-1:0] letter_mask;
    logic                hex_ok;
    logic [3:0]          hex_val;
    logic [PWM_BITS-1:0] duty_new;
    logic [CHANNELS-1:0] pwm_on;

    // Byte classification: channel letters (either case) and hex digits.
    // The channel is carried as a one-hot mask so no array is indexed
    // by a wider-than-needed letter index.
    always_comb begin
        is_upper   = (rx_data >= 8'h41) && (rx_data <= 8'h5A);
        is_lower   = (rx_data >= 8'h61) && (rx_data <= 8'h7A);
        letter_idx = '0;
        if (is_upper) begin
            letter_idx = 5'(rx_data - 8'h41);
        end else if (is_lower) begin
            letter_idx = 5'(rx_data - 8'h61);
        end
        letter_ok   = (is_upper || is_lower) && (int'(letter_idx) < CHANNELS);
        letter_mask = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (letter_idx == 5'(i)) begin
                letter_mask[i] = 1'b1;
            end
        end
        hex_ok  = 1'b1;
        hex_val = '0;
        if ((rx_data >= 8'h30) && (rx_data <= 8'h39)) begin
            hex_val = 4'(rx_data - 8'h30);
        end else if ((rx_data >= 8'h41) && (rx_data <= 8'h46)) begin
            hex_val = 4'(rx_data - 8'h37);
        end else if ((rx_data >= 8'h61) && (rx_data <= 8'h66)) begin
            hex_val = 4'(rx_data - 8'h57);
        end else begin
            hex_ok = 1'b0;
        end
        duty_new = PWM_BITS'(hex_val >> (4 - PWM_BITS));
    end

    // Parser next state, channel register updates and idle timeout.
    // A byte on the expiry cycle wins over the timeout.
    always_comb begin
        state_d    = state_q;
        force_d    = force_q;
        blink_en_d = blink_en_q;
        duty_d     = duty_q;
        ch_mask_d  = ch_mask_q;
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = 1'b0;
        if (rx_valid) begin
            tmo_cnt_d = '0;
            state_d   = S_IDLE;
            case (state_q)
                S_IDLE: begin
                    if (rx_data == 8'h40) begin
                        force_d = '1;
                    end else if (rx_data == 8'h60) begin
                        force_d = '0;
                    end else if (letter_ok && is_upper) begin
                        force_d = force_q | letter_mask;
                    end else if (letter_ok && is_lower) begin
                        force_d = force_q & ~letter_mask;
                    end else if (rx_data == 8'h23) begin
                        state_d = S_DUTY_CH;
                    end else if (rx_data == 8'h21) begin
                        state_d = S_BLINK_CH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_DUTY_CH: begin
                    if (letter_ok) begin
                        ch_mask_d = letter_mask;
                        state_d   = S_DUTY_VAL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_DUTY_VAL: begin
                    if (hex_ok) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            if (ch_mask_q[i]) begin
                                duty_d[i] = duty_new;
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_BLINK_CH: begin
                    if (letter_ok) begin
                        blink_en_d = blink_en_q ^ letter_mask;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (tmo_cnt_q == TMO_LAST) begin
                state_d   = S_IDLE;
                err_d     = 1'b1;
                tmo_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
    end

    // Parser and channel configuration registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            force_q    <= '0;
            blink_en_q <= '0;
            duty_q     <= '1;
            ch_mask_q  <= '0;
            tmo_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            force_q    <= force_d;
            blink_en_q <= blink_en_d;
            duty_q     <= duty_d;
            ch_mask_q  <= ch_mask_d;
            tmo_cnt_q  <= tmo_cnt_d;
            err_q      <= err_d;
        end
    end

    // PWM compare; an all-ones duty never meets the counter so stays on.
    always_comb begin
        pwm_on = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_on[i] = (pwm_cnt_q < duty_q[i]);
        end
    end

    // PWM counter, blink divider and registered LED drive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            led_q         <= '0;
        end else begin
            pwm_cnt_q <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
            led_q <= (force_q | overlay) & pwm_on & (~blink_en_q | {CHANNELS{blink_phase_q}});
        end
    end

    assign led         = led_q;
    assign force_state = force_q;
    assign cmd_err     = err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_led_channel_ctrl.sv
// Directed bench for led_channel_ctrl with short blink and timeout periods.
module tb_led_channel_ctrl;

    localparam int CH = 8;
    localparam int PB = 3;
    localparam int BD = 4;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic [CH-1:0] overlay = '0;
    logic [CH-1:0] led;
    logic [CH-1:0] force_state;
    logic          cmd_err;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    led_channel_ctrl #(
        .CHANNELS (CH),
        .PWM_BITS (PB),
        .BLINK_DIV(BD),
        .TIMEOUT  (TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .overlay    (overlay),
        .led        (led),
        .force_state(force_state),
        .cmd_err    (cmd_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte is sampled on the posedge between the two negedges; returns at
    // the negedge right after the sampling edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic count_on(input logic [CH-1:0] mask, input int n, output int ones);
        ones = 0;
        repeat (n) begin
            @(negedge clk);
            if ((led & mask) != '0) ones++;
        end
    endtask

    initial begin
        int ones, busy_cnt, err_cnt, diff4, edges;
        logic [CH-1:0] led_or, led_and;
        bit s [24];

        // reset state
        repeat (2) @(negedge clk);
        check("rst_led", 32'(led), 32'h0);
        check("rst_force", 32'(force_state), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(cmd_err), 32'h0);
        reset_n = 1'b1;

        // 'C' sets force[2]; led follows one edge after the sampling edge
        send(8'h43);
        check("C_force", 32'(force_state), 32'h04);
        check("C_led_pipe", 32'(led), 32'h00);
        @(negedge clk);
        check("C_led", 32'(led), 32'h04);
        count_on(8'h04, 14, ones);
        check("C_led_steady", 32'(ones), 32'd14);

        // bytes without rx_valid are ignored
        rx_data = 8'h60;
        repeat (5) @(negedge clk);
        rx_data = 8'h00;
        check("novalid_force", 32'(force_state), 32'h04);

        // 'c' clears, 'J' out of range, '?' unknown
        send(8'h63);
        check("c_force", 32'(force_state), 32'h00);
        send(8'h43);
        send(8'h4A);
        check("J_err", 32'(cmd_err), 32'h1);
        check("J_force", 32'(force_state), 32'h04);
        @(negedge clk);
        check("J_err_pulse", 32'(cmd_err), 32'h0);
        send(8'h3F);
        check("q_err", 32'(cmd_err), 32'h1);
        check("q_busy", 32'(busy), 32'h0);

        // '@' then duty of channel B set to zero
        do_reset();
        send(8'h40);
        check("at_force", 32'(force_state), 32'hFF);
        send(8'h23);
        check("hash_busy", 32'(busy), 32'h1);
        send(8'h42);
        check("B_busy", 32'(busy), 32'h1);
        send(8'h30);
        check("zero_busy", 32'(busy), 32'h0);
        check("zero_err", 32'(cmd_err), 32'h0);
        repeat (2) @(negedge clk);
        led_or = '0;
        led_and = '1;
        repeat (14) begin
            @(negedge clk);
            led_or  = led_or | led;
            led_and = led_and & led;
        end
        check("duty0_or", 32'(led_or), 32'hFD);
        check("duty0_and", 32'(led_and), 32'hFD);

        // duty 4 of 7 on channel A
        do_reset();
        send(8'h41);
        send(8'h23);
        send(8'h41);
        send(8'h38);
        repeat (2) @(negedge clk);
        count_on(8'h01, 14, ones);
        check("duty4_on", 32'(ones), 32'd8);
        count_on(8'hFE, 14, ones);
        check("duty4_others", 32'(ones), 32'd0);

        // lowercase channel and hex: 'f' -> 7 always on
        send(8'h23);
        send(8'h61);
        send(8'h66);
        repeat (2) @(negedge clk);
        count_on(8'h01, 14, ones);
        check("dutyF_on", 32'(ones), 32'd14);

        // '1' >> 1 = 0 -> always off
        send(8'h23);
        send(8'h41);
        send(8'h31);
        repeat (2) @(negedge clk);
        count_on(8'h01, 14, ones);
        check("duty1_on", 32'(ones), 32'd0);

        // non-hex in DUTY_VAL
        send(8'h23);
        send(8'h41);
        send(8'h47);
        check("G_err", 32'(cmd_err), 32'h1);
        check("G_busy", 32'(busy), 32'h0);

        // blink on channel A: 4 on / 4 off
        do_reset();
        send(8'h41);
        send(8'h21);
        send(8'h41);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            s[k] = led[0];
        end
        diff4 = 0;
        edges = 0;
        ones = 0;
        for (int k = 0; k < 16; k++) begin
            if (s[k] != s[k+4]) diff4++;
            if (s[k] != s[k+1]) edges++;
            if (s[k]) ones++;
        end
        check("blink_halves", 32'(diff4), 32'd16);
        check("blink_edges", 32'(edges), 32'd4);
        check("blink_ones", 32'(ones), 32'd8);
        send(8'h21);
        send(8'h41);
        repeat (2) @(negedge clk);
        count_on(8'h01, 16, ones);
        check("blink_off", 32'(ones), 32'd16);

        // non-letter in BLINK_CH
        send(8'h21);
        send(8'h35);
        check("blink_bad_err", 32'(cmd_err), 32'h1);
        check("blink_bad_busy", 32'(busy), 32'h0);

        // overlay ORs into the drive
        do_reset();
        overlay = 8'h81;
        repeat (2) @(negedge clk);
        check("overlay_led", 32'(led), 32'h81);
        overlay = '0;

        // timeout after a lone '#'
        do_reset();
        send(8'h23);
        busy_cnt = 0;
        err_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            if (busy) busy_cnt++;
            if (cmd_err) err_cnt++;
            @(negedge clk);
        end
        check("tmo_busy_cycles", 32'(busy_cnt), 32'(TO));
        check("tmo_err_pulses", 32'(err_cnt), 32'd1);
        check("tmo_busy_end", 32'(busy), 32'h0);

        // byte on the expiry cycle is processed, no timeout pulse
        do_reset();
        send(8'h23);
        repeat (TO - 2) @(negedge clk);
        send(8'h42);
        check("race_err", 32'(cmd_err), 32'h0);
        check("race_busy", 32'(busy), 32'h1);
        send(8'h30);
        check("race_done_busy", 32'(busy), 32'h0);
        check("race_done_err", 32'(cmd_err), 32'h0);
        check("race_force", 32'(force_state), 32'h00);

        // reset mid-command discards it
        do_reset();
        send(8'h23);
        #2 reset_n = 1'b0;
        #1 check("rst_mid_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        send(8'h42);
        check("post_rst_B", 32'(force_state), 32'h02);
        check("post_rst_B_err", 32'(cmd_err), 32'h0);
        send(8'h30);
        check("post_rst_0_err", 32'(cmd_err), 32'h1);
        check("post_rst_0_force", 32'(force_state), 32'h02);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
